// File: rtl/tblink_rpc_hdl_pkg.sv
// Shared types for the tblink_rpc HDL-side invoke dispatch path.
package tblink_rpc_hdl_pkg;

    localparam int unsigned CIDW_DEF = 64;
    localparam int unsigned MW_DEF   = 16;
    localparam int unsigned PW_DEF   = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } dispatch_state_e;

    typedef struct packed {
        logic [CIDW_DEF-1:0] call_id;
        logic [MW_DEF-1:0]   method;
        logic [PW_DEF-1:0]   param;
    } invoke_req_t;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
        lowest_set_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) lowest_set_idx = 5'(i);
        end
    endfunction

endpackage

// File: rtl/tblink_rpc_req_fifo.sv
// Request buffer for the invoke dispatcher: simple synchronous FIFO, no bypass.
module tblink_rpc_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tblink_rpc_invoke_dispatch.sv
// Buffers shim invoke requests, issues them to a BFM under tag, returns call_id-tagged completions.
// Optional TBLINK_RPC_DISPATCH_STATS_EN adds issue/completion/stall counters.
//
//  state | meaning
//  RUN   | issuing from the FIFO whenever a tag is free
//  DRAIN | quiesce requested: no issue, outstanding calls still complete
//  IDLE  | quiesced with no outstanding calls and no pending completion
module tblink_rpc_invoke_dispatch
    import tblink_rpc_hdl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NTAGS = 4,
    parameter int MW    = 16,
    parameter int PW    = 64,
    parameter int DW    = 64,
    parameter int CIDW  = 64,
    localparam int TW   = (NTAGS > 1) ? $clog2(NTAGS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CIDW-1:0] req_call_id,
    input  logic [MW-1:0]   req_method,
    input  logic [PW-1:0]   req_param,
    output logic            bfm_valid,
    input  logic            bfm_ready,
    output logic [TW-1:0]   bfm_tag,
    output logic [MW-1:0]   bfm_method,
    output logic [PW-1:0]   bfm_param,
    input  logic            bfm_rsp_valid,
    output logic            bfm_rsp_ready,
    input  logic [TW-1:0]   bfm_rsp_tag,
    input  logic [DW-1:0]   bfm_rsp_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [CIDW-1:0] rsp_call_id,
    output logic [DW-1:0]   rsp_data,
    input  logic            quiesce,
    output logic            idle,
    output logic            err_bad_tag
`ifdef TBLINK_RPC_DISPATCH_STATS_EN
    ,
    output logic [31:0]     stat_issued,
    output logic [31:0]     stat_completed,
    output logic [31:0]     stat_stall
`endif
);

    localparam int FW    = CIDW + MW + PW;
    localparam int NSLOT = 1 << TW;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [FW-1:0]   fifo_rdata;
    logic [CIDW-1:0] head_call_id;
    logic [MW-1:0]   head_method;
    logic [PW-1:0]   head_param;

    dispatch_state_e state_q;
    dispatch_state_e state_d;

    // Slot table sized to the full tag space so any incoming tag indexes safely;
    // slots at or above NTAGS are never allocated and therefore read as free.
    logic [NSLOT-1:0] busy_q;
    logic [CIDW-1:0]  slot_call_id [NSLOT];
    logic [NTAGS-1:0] free_mask;
    logic             have_free;
    logic [TW-1:0]    alloc_tag;
    logic             issue_ok;
    logic             issue;
    logic             rsp_hit;
    logic             good_cpl;
    logic             bad_cpl;

    assign fifo_push = req_valid && req_ready;
    assign req_ready = !fifo_full;
    assign {head_call_id, head_method, head_param} = fifo_rdata;

    tblink_rpc_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_req_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data ({req_call_id, req_method, req_param}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Allocation only sees registered busy bits, so a slot freed this cycle is reusable next cycle.
    assign free_mask = ~busy_q[NTAGS-1:0];
    assign have_free = |free_mask;
    assign alloc_tag = TW'(lowest_set_idx(32'(free_mask)));

    assign issue_ok   = (state_q == RUN) && !fifo_empty && have_free;
    assign issue      = issue_ok && bfm_ready;
    assign fifo_pop   = issue;
    assign bfm_valid  = issue_ok;
    assign bfm_tag    = issue_ok ? alloc_tag   : '0;
    assign bfm_method = issue_ok ? head_method : '0;
    assign bfm_param  = issue_ok ? head_param  : '0;

    assign bfm_rsp_ready = !rsp_valid || rsp_ready;
    assign rsp_hit       = bfm_rsp_valid && bfm_rsp_ready;
    assign good_cpl      = rsp_hit && busy_q[bfm_rsp_tag];
    assign bad_cpl       = rsp_hit && !busy_q[bfm_rsp_tag];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            if (issue)    busy_q[alloc_tag]   <= 1'b1;
            if (good_cpl) busy_q[bfm_rsp_tag] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (issue) slot_call_id[alloc_tag] <= head_call_id;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp_valid   <= 1'b0;
            rsp_call_id <= '0;
            rsp_data    <= '0;
            err_bad_tag <= 1'b0;
        end else begin
            if (good_cpl) begin
                rsp_valid   <= 1'b1;
                rsp_call_id <= slot_call_id[bfm_rsp_tag];
                rsp_data    <= bfm_rsp_data;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (bad_cpl) err_bad_tag <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (quiesce) state_d = DRAIN;
            end
            DRAIN: begin
                if (!quiesce)                       state_d = RUN;
                else if (busy_q == '0 && !rsp_valid) state_d = IDLE;
            end
            IDLE: begin
                if (!quiesce) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign idle = (state_q == IDLE);

`ifdef TBLINK_RPC_DISPATCH_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stat_issued    <= '0;
            stat_completed <= '0;
            stat_stall     <= '0;
        end else begin
            if (issue)    stat_issued    <= stat_issued + 32'd1;
            if (good_cpl) stat_completed <= stat_completed + 32'd1;
            if ((state_q == RUN) && !fifo_empty && !have_free) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tblink_rpc_invoke_dispatch.sv
// Directed self-checking bench for tblink_rpc_invoke_dispatch (default parameters).
module tb_tblink_rpc_invoke_dispatch;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_call_id = '0;
   logic [15:0] req_method = '0;
   logic [63:0] req_param = '0;
   logic        bfm_valid;
   logic        bfm_ready = 1'b0;
   logic [1:0]  bfm_tag;
   logic [15:0] bfm_method;
   logic [63:0] bfm_param;
   logic        bfm_rsp_valid = 1'b0;
   logic        bfm_rsp_ready;
   logic [1:0]  bfm_rsp_tag = '0;
   logic [63:0] bfm_rsp_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_call_id;
   logic [63:0] rsp_data;
   logic        quiesce = 1'b0;
   logic        idle;
   logic        err_bad_tag;
`ifdef TBLINK_RPC_DISPATCH_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_completed;
   logic [31:0] stat_stall;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   tblink_rpc_invoke_dispatch dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_call_id   (req_call_id),
      .req_method    (req_method),
      .req_param     (req_param),
      .bfm_valid     (bfm_valid),
      .bfm_ready     (bfm_ready),
      .bfm_tag       (bfm_tag),
      .bfm_method    (bfm_method),
      .bfm_param     (bfm_param),
      .bfm_rsp_valid (bfm_rsp_valid),
      .bfm_rsp_ready (bfm_rsp_ready),
      .bfm_rsp_tag   (bfm_rsp_tag),
      .bfm_rsp_data  (bfm_rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_call_id   (rsp_call_id),
      .rsp_data      (rsp_data),
      .quiesce       (quiesce),
      .idle          (idle),
      .err_bad_tag   (err_bad_tag)
`ifdef TBLINK_RPC_DISPATCH_STATS_EN
      ,
      .stat_issued    (stat_issued),
      .stat_completed (stat_completed),
      .stat_stall     (stat_stall)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; returns at the following falling edge where outputs are stable.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic push(input logic [63:0] cid, input logic [15:0] m, input logic [63:0] p);
      req_valid   = 1'b1;
      req_call_id = cid;
      req_method  = m;
      req_param   = p;
      step();
      req_valid = 1'b0;
   endtask

   task automatic respond(input logic [1:0] tag, input logic [63:0] data);
      bfm_rsp_valid = 1'b1;
      bfm_rsp_tag   = tag;
      bfm_rsp_data  = data;
      step();
      bfm_rsp_valid = 1'b0;
   endtask

   initial begin
      #100000;
      n_fail++;
      $error("FAIL timeout: test sequence did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      @(negedge clock);
      step();
      step();
      reset_n = 1'b1;

      // Reset values
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_bfm_rsp_ready", bfm_rsp_ready, 1'b1);
      chk("rst_bfm_valid", bfm_valid, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_idle", idle, 1'b0);
      chk("rst_err", err_bad_tag, 1'b0);
      chk("rst_rsp_call_id", rsp_call_id, 64'h0);

      // 1. Single call
      bfm_ready = 1'b1;
      rsp_ready = 1'b1;
      req_valid   = 1'b1;
      req_call_id = 64'h11;
      req_method  = 16'd3;
      req_param   = 64'h55;
      #1;
      chk("t1_no_bypass", bfm_valid, 1'b0);
      step();
      req_valid = 1'b0;
      chk("t1_bfm_valid", bfm_valid, 1'b1);
      chk("t1_bfm_tag", bfm_tag, 2'd0);
      chk("t1_bfm_method", bfm_method, 16'd3);
      chk("t1_bfm_param", bfm_param, 64'h55);
      step();
      chk("t1_issued", bfm_valid, 1'b0);
      respond(2'd0, 64'hAB);
      chk("t1_rsp_valid", rsp_valid, 1'b1);
      chk("t1_rsp_call_id", rsp_call_id, 64'h11);
      chk("t1_rsp_data", rsp_data, 64'hAB);
      chk("t1_idle", idle, 1'b0);
      step();
      chk("t1_rsp_taken", rsp_valid, 1'b0);

      // 2. Out-of-order completions
      push(64'd1, 16'd1, 64'd1);
      push(64'd2, 16'd2, 64'd2);
      push(64'd3, 16'd3, 64'd3);
      chk("t2_bfm_tag", bfm_tag, 2'd2);
      chk("t2_bfm_method", bfm_method, 16'd3);
      step();
      chk("t2_all_issued", bfm_valid, 1'b0);
      respond(2'd2, 64'h2222);
      chk("t2_cid_a", rsp_call_id, 64'd3);
      chk("t2_data_a", rsp_data, 64'h2222);
      respond(2'd0, 64'h1010);
      chk("t2_valid_b", rsp_valid, 1'b1);
      chk("t2_cid_b", rsp_call_id, 64'd1);
      chk("t2_data_b", rsp_data, 64'h1010);
      respond(2'd1, 64'h2020);
      chk("t2_cid_c", rsp_call_id, 64'd2);
      chk("t2_data_c", rsp_data, 64'h2020);
      step();
      chk("t2_rsp_done", rsp_valid, 1'b0);

      // 3. Tag exhaustion
      for (int i = 0; i < 6; i++) push(64'(48 + i), 16'(48 + i), 64'(i));
      chk("t3_stalled", bfm_valid, 1'b0);
      chk("t3_req_ready", req_ready, 1'b1);
`ifdef TBLINK_RPC_DISPATCH_STATS_EN
      chk("t3_stat_issued", stat_issued, 32'd8);
      chk("t3_stat_completed", stat_completed, 32'd4);
      chk("t3_stat_stall", stat_stall, 32'd1);
`endif
      bfm_rsp_valid = 1'b1;
      bfm_rsp_tag   = 2'd1;
      bfm_rsp_data  = 64'h3131;
      #1;
      chk("t3_no_same_cycle", bfm_valid, 1'b0);
      step();
      bfm_rsp_valid = 1'b0;
      chk("t3_free_rsp_cid", rsp_call_id, 64'h31);
      chk("t3_reissue_valid", bfm_valid, 1'b1);
      chk("t3_reissue_tag", bfm_tag, 2'd1);
      chk("t3_reissue_method", bfm_method, 16'h34);
      step();
      chk("t3_full_again", bfm_valid, 1'b0);

      // 4. Response backpressure
      bfm_ready = 1'b0;
      rsp_ready = 1'b0;
      respond(2'd0, 64'hD0);
      chk("t4_rsp_valid", rsp_valid, 1'b1);
      chk("t4_cid_first", rsp_call_id, 64'h30);
      chk("t4_bfm_rsp_ready", bfm_rsp_ready, 1'b0);
      bfm_rsp_valid = 1'b1;
      bfm_rsp_tag   = 2'd2;
      bfm_rsp_data  = 64'hD2;
      step();
      step();
      chk("t4_held_cid", rsp_call_id, 64'h30);
      chk("t4_held_data", rsp_data, 64'hD0);
      rsp_ready = 1'b1;
      #1;
      chk("t4_release_ready", bfm_rsp_ready, 1'b1);
      step();
      bfm_rsp_valid = 1'b0;
      chk("t4_second_valid", rsp_valid, 1'b1);
      chk("t4_second_cid", rsp_call_id, 64'h32);
      chk("t4_second_data", rsp_data, 64'hD2);
      step();
      chk("t4_drained", rsp_valid, 1'b0);

      // 5. Quiesce: tags 1,3 outstanding, 0x35 queued
      quiesce = 1'b1;
      step();
      chk("t5_no_issue", bfm_valid, 1'b0);
      bfm_ready = 1'b1;
      step();
      chk("t5_still_no_issue", bfm_valid, 1'b0);
      chk("t5_not_idle", idle, 1'b0);
      respond(2'd1, 64'h5151);
      chk("t5_cid_a", rsp_call_id, 64'h34);
      respond(2'd3, 64'h5353);
      chk("t5_cid_b", rsp_call_id, 64'h33);
      chk("t5_data_b", rsp_data, 64'h5353);
      chk("t5_pending_not_idle", idle, 1'b0);
      step();
      chk("t5_drain_wait", idle, 1'b0);
      step();
      chk("t5_idle", idle, 1'b1);
      chk("t5_idle_no_issue", bfm_valid, 1'b0);
      quiesce = 1'b0;
      step();
      chk("t5_resume_idle", idle, 1'b0);
      chk("t5_resume_valid", bfm_valid, 1'b1);
      chk("t5_resume_tag", bfm_tag, 2'd0);
      chk("t5_resume_method", bfm_method, 16'h35);
      chk("t5_resume_param", bfm_param, 64'd5);
      step();
      chk("t5_resume_issued", bfm_valid, 1'b0);

      // FIFO full boundary
      bfm_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(64'(112 + i), 16'(112 + i), 64'(i));
      chk("full_req_ready", req_ready, 1'b0);
      chk("full_bfm_tag", bfm_tag, 2'd1);
      chk("full_bfm_method", bfm_method, 16'h70);
      bfm_ready = 1'b1;
      step();
      bfm_ready = 1'b0;
      chk("full_pop_ready", req_ready, 1'b1);

      // 6. Bad tag, then reset mid-traffic
      respond(2'd3, 64'hBAD);
      chk("t6_err", err_bad_tag, 1'b1);
      chk("t6_no_rsp", rsp_valid, 1'b0);
      step();
      chk("t6_err_sticky", err_bad_tag, 1'b1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("t6_rst_bfm_valid", bfm_valid, 1'b0);
      chk("t6_rst_req_ready", req_ready, 1'b1);
      chk("t6_rst_bfm_rsp_ready", bfm_rsp_ready, 1'b1);
      chk("t6_rst_err", err_bad_tag, 1'b0);
      chk("t6_rst_rsp_valid", rsp_valid, 1'b0);
      chk("t6_rst_idle", idle, 1'b0);
      chk("t6_rst_rsp_call_id", rsp_call_id, 64'h0);
      chk("t6_rst_rsp_data", rsp_data, 64'h0);
      respond(2'd0, 64'h1);
      chk("t6_tags_cleared", err_bad_tag, 1'b1);
      chk("t6_tags_cleared_rsp", rsp_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
